// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word type and store-path state encoding
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } lc3b_store_state;

    function automatic lc3b_word word_align(input lc3b_word addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/store_lane_fmt.sv
// rtl/store_lane_fmt.sv - places store data on the byte lanes and flags misaligned words
module store_lane_fmt
    import lc3b_types::*;
(
    input  logic       byte_store,
    input  logic       addr_lsb,
    input  lc3b_word   data,
    output lc3b_word   wdata,
    output logic [1:0] byte_enable,
    output logic       misaligned
);

    always_comb begin
        wdata       = data;
        byte_enable = 2'b11;
        misaligned  = 1'b0;
        if (byte_store) begin
            // Byte is replicated on both lanes; the enable picks the lane that lands.
            wdata       = {data[7:0], data[7:0]};
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
        end else begin
            misaligned  = addr_lsb;
        end
    end

endmodule

// File: rtl/store_format_unit.sv
// rtl/store_format_unit.sv - registers a formatted store and drives one memory write with timeout
module store_format_unit
    import lc3b_types::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_byte,
    input  lc3b_word   req_addr,
    input  lc3b_word   req_data,
    output lc3b_word   mem_address,
    output lc3b_word   mem_wdata,
    output logic [1:0] mem_byte_enable,
    output logic       mem_write,
    input  logic       mem_resp,
    output logic       done,
    output logic       err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lc3b_store_state state_q, state_d;
    lc3b_word        addr_q, addr_d;
    lc3b_word        wdata_q, wdata_d;
    logic [1:0]      be_q, be_d;
    logic            write_q, write_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ready_q, ready_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    lc3b_word   fmt_wdata;
    logic [1:0] fmt_be;
    logic       fmt_misaligned;

    store_lane_fmt u_lane_fmt (
        .byte_store  (req_byte),
        .addr_lsb    (req_addr[0]),
        .data        (req_data),
        .wdata       (fmt_wdata),
        .byte_enable (fmt_be),
        .misaligned  (fmt_misaligned)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        write_d = write_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = word_align(req_addr);
                    wdata_d = fmt_wdata;
                    ready_d = 1'b0;
                    if (fmt_misaligned) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = WRITE;
                        write_d = 1'b1;
                        be_d    = fmt_be;
                        cnt_d   = '0;
                    end
                end
            end
            WRITE: begin
                // A response on the final timeout cycle still counts as success.
                if (mem_resp || cnt_q == CNT_LAST) begin
                    state_d = DONE;
                    write_d = 1'b0;
                    be_d    = 2'b00;
                    done_d  = 1'b1;
                    err_d   = !mem_resp;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
                be_d    = 2'b00;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 2'b00;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            write_q <= write_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready       = ready_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;
    assign mem_write       = write_q;
    assign done            = done_q;
    assign err             = err_q;

endmodule
